// File: rtl/exmem_stage_reg.sv
// rtl/exmem_stage_reg.sv - EX/MEM pipeline stage register with valid/ready handshake, optional skid buffer and flush
//
// Purpose: holds the instruction leaving execute until the memory unit takes it.
//   With SKID=1 a second register absorbs one extra entry during a memory stall,
//   so in_ready can be registered and never depends on out_ready.
//   With SKID=0 only the head register exists and in_ready is combinational.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   in_valid / in_ready           upstream handshake from EX
//   flush                         drops every held entry and the incoming one
//   *_in                          control bits and payload from EX
//   out_valid / out_ready         downstream handshake to MEM
//   *_out                         head entry; control bits gated by out_valid

module exmem_stage_reg #(
    parameter int DATA_W     = 16,
    parameter int REG_ADDR_W = 4,
    parameter int SKID       = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  flush,
    input  logic                  reg_write_in,
    input  logic                  mem_write_in,
    input  logic                  mem_read_in,
    input  logic                  call_in,
    input  logic                  mem_to_reg_in,
    input  logic                  ret_future_in,
    input  logic [REG_ADDR_W-1:0] reg_rd_in,
    input  logic [DATA_W-1:0]     alu_result_in,
    input  logic [DATA_W-1:0]     store_data_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  reg_write_out,
    output logic                  mem_write_out,
    output logic                  mem_read_out,
    output logic                  call_out,
    output logic                  mem_to_reg_out,
    output logic                  ret_future_out,
    output logic [REG_ADDR_W-1:0] reg_rd_out,
    output logic [DATA_W-1:0]     alu_result_out,
    output logic [DATA_W-1:0]     store_data_out
);

    localparam int PW = 6 + REG_ADDR_W + 2 * DATA_W;

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_TWO   = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [PW-1:0]   r_head;
    logic [PW-1:0]   r_skid;
    logic            r_in_ready;
    logic [PW-1:0]   w_in_word;
    logic            w_out_valid;
    logic            w_accept;
    logic            w_consume;
    logic            w_load_head;
    logic            w_load_skid;
    logic            w_move_skid;
    logic [5:0]      w_ctrl;

    assign w_in_word = {reg_write_in, mem_write_in, mem_read_in, call_in,
                        mem_to_reg_in, ret_future_in, reg_rd_in,
                        alu_result_in, store_data_in};

    assign w_out_valid = (r_state != S_EMPTY);

    // Skid mode: ready comes from a register so out_ready never reaches EX
    // combinationally. Both modes hold ready low while reset is asserted.
    generate
        if (SKID != 0) begin : g_skid_ready
            assign in_ready = r_in_ready & ~rst;
        end else begin : g_comb_ready
            assign in_ready = ~rst & (~w_out_valid | out_ready);
        end
    endgenerate

    assign w_accept  = in_valid & in_ready & ~flush;
    assign w_consume = w_out_valid & out_ready;

    always_comb begin
        w_next      = r_state;
        w_load_head = 1'b0;
        w_load_skid = 1'b0;
        w_move_skid = 1'b0;
        case (r_state)
            S_EMPTY: begin
                if (w_accept) begin
                    w_next      = S_ONE;
                    w_load_head = 1'b1;
                end
            end
            S_ONE: begin
                if (w_accept && w_consume) begin
                    w_load_head = 1'b1;
                end else if (w_accept && (SKID != 0)) begin
                    // Only reachable with a skid register: without it, ready
                    // is low whenever the head is full and not draining.
                    w_next      = S_TWO;
                    w_load_skid = 1'b1;
                end else if (w_consume) begin
                    w_next = S_EMPTY;
                end
            end
            S_TWO: begin
                if (w_consume) begin
                    w_next      = S_ONE;
                    w_move_skid = 1'b1;
                end
            end
            default: w_next = S_EMPTY;
        endcase
        // A consume in the same cycle still completes: MEM already sampled it.
        if (flush) begin
            w_next = S_EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_EMPTY;
            r_head     <= '0;
            r_skid     <= '0;
            r_in_ready <= 1'b1;
        end else begin
            r_state    <= w_next;
            r_in_ready <= (w_next != S_TWO);
            if (w_load_head) begin
                r_head <= w_in_word;
            end else if (w_move_skid) begin
                r_head <= r_skid;
            end
            if (w_load_skid) begin
                r_skid <= w_in_word;
            end
        end
    end

    assign out_valid = w_out_valid;
    assign {w_ctrl, reg_rd_out, alu_result_out, store_data_out} = r_head;
    assign {reg_write_out, mem_write_out, mem_read_out, call_out,
            mem_to_reg_out, ret_future_out} = w_ctrl & {6{w_out_valid}};

endmodule

// File: doc/exmem_stage_reg.md
# exmem_stage_reg

Parametrised EX/MEM pipeline stage register with a valid/ready handshake, an optional skid buffer and a synchronous flush. It sits between the execute stage (ALU result, store data, destination register, control bits) and the memory unit. A memory-side stall holds the stage without losing the instruction being produced upstream. A branch or return redirect kills in-flight entries so they cannot write the register file or memory.

## Interface
Parameters:
- DATA_W, 16, width of the ALU result and store-data fields
- REG_ADDR_W, 4, width of the destination register index
- SKID, 1, 1 = two-entry skid buffer with registered in_ready; 0 = single entry with combinational in_ready

Ports:
- clk  in  1  single clock, all state updates on posedge
- rst  in  1  synchronous reset, active-high
- in_valid  in  1  EX presents an instruction
- in_ready  out  1  stage can accept this cycle
- flush  in  1  kill all held entries and the incoming one
- reg_write_in, mem_write_in, mem_read_in, call_in, mem_to_reg_in, ret_future_in  in  1 each  control bits
- reg_rd_in  in  REG_ADDR_W  destination register
- alu_result_in  in  DATA_W  ALU result / memory address
- store_data_in  in  DATA_W  data for memory write
- out_valid  out  1  MEM-side entry valid
- out_ready  in  1  MEM consumes entry this cycle
- reg_write_out, mem_write_out, mem_read_out, call_out, mem_to_reg_out, ret_future_out  out  1 each  control bits, gated by out_valid
- reg_rd_out, alu_result_out, store_data_out  out  REG_ADDR_W/DATA_W/DATA_W  payload of head entry

## Operation
- Entry = all _in fields as one payload word.
- Accept = in_valid & in_ready & !flush. Consume = out_valid & out_ready.
- Output control bits are ANDed with out_valid. An invalid slot never asserts reg_write, mem_write, mem_read or call. Payload outputs hold the last loaded values and are don't-care when out_valid=0.

SKID=1 state machine (head register H, skid register S):
- EMPTY: accept → ONE (load H).
- ONE: accept & consume → ONE (H reloaded); accept & !consume → TWO (load S); consume & !accept → EMPTY; neither → ONE.
- TWO: consume → ONE (S moves into H); in_ready=0, so there is no accept.
- in_ready = (state != TWO), taken from a register. It has no combinational path from out_ready.

SKID=0:
- Only H exists. in_ready = !out_valid | out_ready (combinational).
- EMPTY/ONE transitions are as above. TWO is unreachable.

Flush, rst and ordering:
- flush: next state EMPTY regardless of accept or consume. Any incoming entry is dropped. A consume in the same cycle still completes, because MEM sampled the entry.
- rst: state EMPTY, out_valid=0, gated control outputs=0, payload registers cleared to 0. in_ready is forced 0 while rst=1 and is 1 on the first cycle after.
- rst overrides flush, and flush overrides accept.
- Ordering: entries leave in acceptance order. No entry is duplicated or dropped except by flush/rst.

## Timing
- Latency: accepted at edge N → visible on outputs after edge N (one cycle) when the stage was EMPTY or consumed in the same cycle.
- Throughput: one entry per cycle while out_ready=1, in both modes.
- SKID=1 stall response: in_ready drops one cycle after the stall fills S. At most one extra entry is absorbed.
- SKID=1 release: after the consume that empties S, in_ready rises on the next cycle.
- Reset value of every output: out_valid 0, all control outputs 0, reg_rd_out 0, alu_result_out 0, store_data_out 0. in_ready is 0 during reset and 1 after.
- No combinational path from any _in payload to any _out in either mode.

## Test plan
- Streaming, SKID=1, out_ready=1: alu_result_in 0x0001..0x0008 on consecutive cycles → identical sequence on alu_result_out, one cycle later, no gaps, in_ready stays 1.
- Stall, SKID=1: feed 0xA000, 0xA001, 0xA002 with out_ready=0 from cycle 1 → H=0xA000, S=0xA001, in_ready=0, 0xA002 held upstream; raise out_ready → 0xA000, 0xA001, 0xA002 in order.
- Flush in TWO with in_valid=1, mem_write_in=1 → next cycle out_valid=0 and mem_write_out=0; that entry and both held entries never appear.
- Gating: load reg_write_in=1, reg_rd_in=0x7, then consume with no new input → out_valid=0 and reg_write_out=0, while reg_rd_out may still read 0x7.
- Reset mid-stall in TWO: rst=1 for one cycle → all outputs 0, in_ready=0 during rst and 1 after; the next accepted entry 0x1234 appears alone.
- SKID=0: out_ready=0 with H full → in_ready=0 in the same cycle; out_ready=1 and in_valid=1 → in_ready=1 in the same cycle, and the entry is replaced by the next one.
